// File: rtl/constants_pkg.sv
// Platform-wide physical constants shared across the memory subsystem.
package constants_pkg;

    localparam int PHY_LEN = 32;

endpackage

// File: rtl/mem_pkg.sv
// Types and constants shared by the memory arbiter and its picker.
package mem_pkg;

    import constants_pkg::*;

    localparam int LINE_W_DEFAULT = 128;
    localparam logic [PHY_LEN-1:0] LINE_OFS_MASK = PHY_LEN'(LINE_W_DEFAULT / 8 - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    typedef struct packed {
        logic                      we;
        logic [PHY_LEN-1:0]        addr;
        logic [LINE_W_DEFAULT-1:0] wdata;
    } mem_req_t;

    // Memory is addressed by whole lines, so the byte offset is dropped.
    function automatic logic [PHY_LEN-1:0] line_align(input logic [PHY_LEN-1:0] addr);
        return addr & ~LINE_OFS_MASK;
    endfunction

endpackage

// File: rtl/arb_pick2.sv
// Two-way request picker. MEM_ARB_RR_EN selects round-robin with a last-owner
// flop; otherwise dcache has fixed priority over icache.
module arb_pick2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic i_req,
    input  logic d_req,
    output logic i_pick,
    output logic d_pick
);

`ifdef MEM_ARB_RR_EN
    logic last_d;

    // Resets to "icache last" so the first tie goes to the dcache.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d <= 1'b0;
        end else if (d_pick) begin
            last_d <= 1'b1;
        end else if (i_pick) begin
            last_d <= 1'b0;
        end
    end

    assign d_pick = en & d_req & (~i_req | ~last_d);
`else
    logic unused_clk_rst;
    assign unused_clk_rst = ^{clk, rst};

    assign d_pick = en & d_req;
`endif

    assign i_pick = en & i_req & ~d_pick;

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one line-wide memory port between the
// icache refill and dcache refill/writeback paths. MEM_ARB_RR_EN enables round-robin.
//
// state | meaning
// IDLE  | no transaction; grant a pending request in the same cycle
// ISSUE | mem_req_valid held with latched fields until mem_req_ready
// WAIT  | accepted by memory; next mem_resp_valid goes to the owner
module mem_arbiter
    import constants_pkg::*;
    import mem_pkg::*;
#(
    parameter int ADDR_W = PHY_LEN,
    parameter int LINE_W = LINE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [LINE_W-1:0] mem_resp_rdata,
    output logic              err_spurious
);

    arb_state_t state;
    arb_owner_t owner;
    mem_req_t   lat;
    logic       idle;

    // Gating with rst keeps grants low while reset is held.
    assign idle = (state == IDLE) & rst;

    arb_pick2 u_pick (
        .clk    (clk),
        .rst    (rst),
        .en     (idle),
        .i_req  (i_req),
        .d_req  (d_req),
        .i_pick (i_gnt),
        .d_pick (d_gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            owner         <= OWN_I;
            lat           <= '0;
            mem_req_valid <= 1'b0;
            err_spurious  <= 1'b0;
        end else begin
            if (mem_resp_valid && state != WAIT) begin
                err_spurious <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (d_gnt) begin
                        owner         <= OWN_D;
                        lat.we        <= d_we;
                        lat.addr      <= line_align(d_addr);
                        lat.wdata     <= d_wdata;
                        mem_req_valid <= 1'b1;
                        state         <= ISSUE;
                    end else if (i_gnt) begin
                        owner         <= OWN_I;
                        lat.we        <= 1'b0;
                        lat.addr      <= line_align(i_addr);
                        lat.wdata     <= '0;
                        mem_req_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    mem_req_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_we    = lat.we;
    assign mem_req_addr  = lat.addr;
    assign mem_req_wdata = lat.wdata;

    assign i_rvalid = (state == WAIT) & mem_resp_valid & (owner == OWN_I);
    assign d_rvalid = (state == WAIT) & mem_resp_valid & (owner == OWN_D);
    assign i_rdata  = i_rvalid ? mem_resp_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_resp_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model of the arbiter.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         i_req;
    logic [31:0]  i_addr;
    logic         i_gnt;
    logic         i_rvalid;
    logic [127:0] i_rdata;
    logic         d_req;
    logic         d_we;
    logic [31:0]  d_addr;
    logic [127:0] d_wdata;
    logic         d_gnt;
    logic         d_rvalid;
    logic [127:0] d_rdata;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_we;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_wdata;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_rdata;
    logic         err_spurious;

    mem_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_gnt          (i_gnt),
        .i_rvalid       (i_rvalid),
        .i_rdata        (i_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_gnt          (d_gnt),
        .d_rvalid       (d_rvalid),
        .d_rdata        (d_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .err_spurious   (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: one transaction in flight, either awaiting
    // memory acceptance or awaiting its response.
    bit           busy, acc, own_d, last_d, spur;
    bit           rec_we;
    logic [31:0]  rec_addr;
    logic [127:0] rec_wdata;
    bit           i_drop, d_drop;
    int           order[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        bit e_i, e_d, e_v, waiting, e_irv, e_drv;
        @(negedge clk);
        if (!rst) begin
            chk("rst_i_gnt", i_gnt, 0);
            chk("rst_d_gnt", d_gnt, 0);
            chk("rst_i_rvalid", i_rvalid, 0);
            chk("rst_d_rvalid", d_rvalid, 0);
            chk("rst_i_rdata", i_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
            chk("rst_mem_valid", mem_req_valid, 0);
            chk("rst_mem_we", mem_req_we, 0);
            chk("rst_mem_addr", mem_req_addr, 0);
            chk("rst_mem_wdata", mem_req_wdata, 0);
            chk("rst_err", err_spurious, 0);
            busy = 0; acc = 0; spur = 0; last_d = 0;
        end else begin
            e_d = !busy && d_req && (!i_req || !RR || !last_d);
            e_i = !busy && i_req && !e_d;
            e_v = busy && !acc;
            waiting = busy && acc;
            e_irv = waiting && mem_resp_valid && !own_d;
            e_drv = waiting && mem_resp_valid && own_d;
            chk("i_gnt", i_gnt, e_i);
            chk("d_gnt", d_gnt, e_d);
            chk("mem_valid", mem_req_valid, e_v);
            if (e_v) begin
                chk("mem_we", mem_req_we, rec_we);
                chk("mem_addr", mem_req_addr, rec_addr);
                chk("mem_wdata", mem_req_wdata, rec_wdata);
            end
            chk("i_rvalid", i_rvalid, e_irv);
            chk("d_rvalid", d_rvalid, e_drv);
            chk("i_rdata", i_rdata, e_irv ? mem_resp_rdata : 128'd0);
            chk("d_rdata", d_rdata, e_drv ? mem_resp_rdata : 128'd0);
            chk("err_spurious", err_spurious, spur);
            if (mem_resp_valid && !waiting) spur = 1;
            if (e_d) begin
                busy = 1; acc = 0; own_d = 1; last_d = 1; d_drop = 1;
                rec_we = d_we; rec_addr = d_addr & ~32'hF; rec_wdata = d_wdata;
                order.push_back(1);
            end else if (e_i) begin
                busy = 1; acc = 0; own_d = 0; last_d = 0; i_drop = 1;
                rec_we = 0; rec_addr = i_addr & ~32'hF; rec_wdata = '0;
                order.push_back(0);
            end else if (e_v && mem_req_ready) begin
                acc = 1;
            end else if (waiting && mem_resp_valid) begin
                busy = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand(input int p_ready, input int p_resp, input int p_new);
        if (i_drop) begin i_req = 0; i_drop = 0; end
        if (d_drop) begin d_req = 0; d_drop = 0; end
        if (!i_req && $urandom_range(99) < p_new) begin
            i_req = 1; i_addr = $urandom;
        end
        if (!d_req && $urandom_range(99) < p_new) begin
            d_req = 1; d_we = 1'($urandom_range(1)); d_addr = $urandom;
            d_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
        mem_req_ready  = $urandom_range(99) < p_ready;
        mem_resp_valid = busy && acc && ($urandom_range(99) < p_resp);
        mem_resp_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        int d_left;
        bit done;
        int exp_ord[4];
        rst = 0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
        @(posedge clk); #1;

        // Reset with requests present: nothing granted.
        i_req = 1; d_req = 1;
        repeat (3) check_cycle();
        rst = 1; i_req = 0; d_req = 0;
        check_cycle();

        // icache alone.
        i_req = 1; i_addr = 32'h0000_0040;
        check_cycle();
        i_req = 0; mem_req_ready = 1;
        check_cycle();
        mem_req_ready = 0;
        check_cycle();
        mem_resp_valid = 1; mem_resp_rdata = 128'hDEADBEEF_00000000_00000000_00000001;
        check_cycle();
        mem_resp_valid = 0;
        check_cycle();

        // Two simultaneous ties: D,I,D,I in either mode.
        order.delete();
        for (int t = 0; t < 2; t++) begin
            i_drop = 0; d_drop = 0;
            i_req = 1; i_addr = $urandom;
            d_req = 1; d_we = 1; d_addr = 32'h100;
            d_wdata = {$urandom, $urandom, $urandom, $urandom};
            done = 0;
            for (int k = 0; k < 20 && !done; k++) begin
                check_cycle();
                drive_rand(100, 100, 0);
                done = !i_req && !d_req && !busy;
            end
            chk("tie_done", done, 1);
        end
        chk("tie_count", order.size(), 4);
        for (int k = 0; k < 4 && k < order.size(); k++) chk("tie_order", order[k], k % 2 == 0);

        // Ready held low for 5 cycles with icache waiting.
        i_drop = 0; d_drop = 0; mem_req_ready = 0; mem_resp_valid = 0;
        d_req = 1; d_we = 0; d_addr = 32'h200; d_wdata = 128'h5; i_req = 1; i_addr = 32'h308;
        check_cycle();
        d_req = 0;
        repeat (5) check_cycle();
        mem_req_ready = 1;
        check_cycle();
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = {4{32'hA5A5_0F0F}};
        check_cycle();
        mem_resp_valid = 0;
        check_cycle();
        i_req = 0; mem_req_ready = 1;
        check_cycle();
        mem_req_ready = 0; mem_resp_valid = 1;
        check_cycle();
        mem_resp_valid = 0;
        check_cycle();

        // dcache re-requests back to back while icache waits.
        order.delete(); i_drop = 0; d_drop = 0; d_left = 3; done = 0;
        i_req = 1; i_addr = $urandom;
        d_req = 1; d_we = 1'($urandom_range(1)); d_addr = $urandom;
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 60 && !done; k++) begin
            check_cycle();
            if (d_drop) begin
                d_drop = 0; d_left--;
                if (d_left > 0) begin
                    d_addr = $urandom; d_wdata = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    d_req = 0;
                end
            end
            if (i_drop) begin i_drop = 0; i_req = 0; end
            mem_req_ready = 1;
            mem_resp_valid = busy && acc;
            done = !i_req && !d_req && !busy;
        end
        chk("hold_done", done, 1);
        if (RR) exp_ord = '{1, 0, 1, 1};
        else    exp_ord = '{1, 1, 1, 0};
        chk("hold_count", order.size(), 4);
        for (int k = 0; k < 4 && k < order.size(); k++) chk("hold_order", order[k], exp_ord[k]);

        // Randomized traffic, then drain.
        i_drop = 0; d_drop = 0; mem_resp_valid = 0;
        repeat (3000) begin
            drive_rand(60, 40, 30);
            check_cycle();
        end
        repeat (30) begin
            drive_rand(100, 100, 0);
            check_cycle();
        end
        chk("drain_idle", busy, 0);

        // Reset while waiting for a response; the late response is spurious.
        i_drop = 0; d_drop = 0; i_req = 0; d_req = 0; mem_resp_valid = 0; mem_req_ready = 0;
        i_req = 1; i_addr = 32'h80;
        check_cycle();
        i_req = 0; mem_req_ready = 1;
        check_cycle();
        mem_req_ready = 0;
        check_cycle();
        rst = 0;
        repeat (2) check_cycle();
        rst = 1;
        check_cycle();
        mem_resp_valid = 1; mem_resp_rdata = {4{$urandom}};
        check_cycle();
        mem_resp_valid = 0;
        repeat (3) check_cycle();

        // Response in IDLE with no request: sticky error, still idle.
        rst = 0;
        check_cycle();
        rst = 1;
        check_cycle();
        mem_resp_valid = 1;
        check_cycle();
        mem_resp_valid = 0;
        repeat (4) check_cycle();
        chk("idle_spur_sticky", err_spurious, 1);
        i_req = 1; i_addr = 32'h1234;
        check_cycle();
        i_req = 0; mem_req_ready = 1;
        check_cycle();
        mem_req_ready = 0; mem_resp_valid = 1;
        check_cycle();
        mem_resp_valid = 0;
        check_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing one line-wide memory interface between the instruction cache refill path and the data cache refill/writeback path. Sits between the two caches and the memory model: it accepts one transaction at a time, drives it to memory, and routes the response back to its owner. Only one transaction is outstanding at any time. The arbiter never reorders a requester's own traffic.

## Interface

Parameters:
- ADDR_W, 32: physical address width; matches PHY_LEN.
- LINE_W, 128: cache line width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  icache refill request; held until i_gnt.
- i_addr  in  ADDR_W  icache line address; low log2(LINE_W/8) bits ignored.
- i_gnt  out  1  one-cycle pulse: icache request accepted.
- i_rvalid  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  LINE_W  refill line.
- d_req  in  1  dcache request; held with fields stable until d_gnt.
- d_we  in  1  1 = writeback, 0 = refill.
- d_addr  in  ADDR_W  dcache line address.
- d_wdata  in  LINE_W  writeback line.
- d_gnt  out  1  one-cycle pulse: dcache request accepted.
- d_rvalid  out  1  one-cycle pulse: read data valid or write acknowledged.
- d_rdata  out  LINE_W  refill line; don't-care for writes.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request when high with valid.
- mem_req_we, mem_req_addr, mem_req_wdata  out  1/ADDR_W/LINE_W  latched request fields.
- mem_resp_valid  in  1  one-cycle response pulse (read data or write ack).
- mem_resp_rdata  in  LINE_W  read data.
- err_spurious  out  1  sticky: mem_resp_valid seen outside WAIT.

## Operation

- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any request is pending, pick a winner, assert its gnt combinationally in the same cycle, and latch owner, we, addr and wdata (icache: we=0, wdata=0). Then go to ISSUE. With no request, stay in IDLE.
- ISSUE: hold mem_req_valid=1 with latched fields stable. On mem_req_ready, go to WAIT.
- WAIT: on mem_resp_valid, pulse the owner's rvalid in the same cycle. rdata is driven combinationally from mem_resp_rdata. Then go to IDLE.
- Fixed priority (default): dcache wins over icache when both request.
- A requester whose request is pending but not granted keeps req high. Its fields must not change; the bench checks this as a protocol assertion.
- Non-owner rvalid stays 0. i_rdata and d_rdata are 0 when their rvalid is 0.
- mem_resp_valid in IDLE or ISSUE is ignored and sets err_spurious, which clears only on reset.
- Reset (any cycle, including mid-ISSUE or mid-WAIT):
  - state returns to IDLE;
  - all outputs go to 0;
  - the in-flight transaction is dropped and any later response to it flags err_spurious.

## Timing

- Request at cycle 0 in IDLE: gnt at cycle 0.
- mem_req_valid is asserted from cycle 1. With ready at cycle 1, WAIT starts at cycle 2.
- Earliest rvalid is cycle 2 (mem_resp_valid at cycle 2). IDLE is at cycle 3, and the next gnt is at cycle 3 earliest.
- Minimum occupancy is 3 cycles per transaction. Back-to-back throughput is 1 transaction per 3 cycles plus memory latency.
- No combinational path from mem_req_ready to any mem_req_* output. gnt depends combinationally only on req and state.

## Configuration

- MEM_ARB_RR_EN defined: two-way round-robin.
  - A 1-bit last-owner register is updated on every grant.
  - On a simultaneous request, the requester not granted last wins.
  - The register resets to "icache last", so dcache wins the first tie.
- MEM_ARB_RR_EN undefined: fixed dcache-over-icache priority and no last-owner register.
- A single requester is granted immediately in both modes.

## Structure

- Shared package mem_pkg holds:
  - LINE_W default constant;
  - arb_state_t enum (IDLE, ISSUE, WAIT);
  - arb_owner_t enum (OWN_I, OWN_D);
  - mem_req_t packed struct (we, addr, wdata) used for the latched request.
- ADDR_W is taken from PHY_LEN in constants_pkg.
- Optional sub-module arb_pick2: combinational 2-input picker (fixed or round-robin via MEM_ARB_RR_EN) plus the last-owner flop. The FSM and latch stay in mem_arbiter.

## Test plan

- icache alone: i_req, i_addr=0x0000_0040, ready immediate, response 3 cycles later with rdata=0xDEADBEEF_…_0001 -> i_gnt at cycle 0, mem_req_addr=0x40 with we=0, i_rvalid with matching data, d_rvalid stays 0.
- Simultaneous i_req and d_req (d_we=1, d_addr=0x100) without the macro -> d_gnt first and write issued with d_wdata. d_rvalid on ack, then i_gnt in the next IDLE cycle.
- Same tie repeated twice with MEM_ARB_RR_EN -> grant order D, I, then D, I, with alternation on each tie.
- mem_req_ready held low 5 cycles -> mem_req_valid and fields stable for all 5 cycles, no gnt to the other requester during that time.
- Reset asserted in WAIT, then mem_resp_valid after release -> all outputs 0 during reset, no rvalid, err_spurious=1.
- mem_resp_valid in IDLE with no request -> err_spurious set and sticky, state stays IDLE, no rvalid.
